// File: rtl/rx_stream_packer_pkg.sv
// Shared widths and output FSM encoding for the receive-side stream packer.
package rx_stream_packer_pkg;

  localparam int unsigned StreamWidth = 32;
  localparam int unsigned OvfWidth    = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSendI = 2'd1,
    StSendQ = 2'd2
  } tx_state_e;

endpackage

// File: rtl/rx_stream_packer_if.sv
// AXI4-Stream beat channel carrying sign-extended I/Q words.
interface rx_stream_packer_if;
  import rx_stream_packer_pkg::*;

  logic [StreamWidth-1:0] tdata;
  logic                   tvalid;
  logic                   tready;
  logic                   tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/rx_stream_packer_sync_fifo.sv
// Single-clock FWFT FIFO; exposes the head, the entry behind it and the fill level.
module rx_stream_packer_sync_fifo #(
    parameter int unsigned Width     = 48,
    parameter int unsigned DepthLog2 = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 push_i,
    input  logic [Width-1:0]     wdata_i,
    input  logic                 pop_i,
    output logic [Width-1:0]     head_o,
    output logic [Width-1:0]     head_next_o,
    output logic [DepthLog2:0]   level_o,
    output logic                 full_o,
    output logic                 empty_o
);

  localparam int unsigned Depth = 1 << DepthLog2;
  localparam logic [DepthLog2:0]   PtrOne = 1;
  localparam logic [DepthLog2-1:0] IdxOne = 1;

  logic [Width-1:0]   mem_q [Depth];
  logic [DepthLog2:0] wr_ptr_q, wr_ptr_d;
  logic [DepthLog2:0] rd_ptr_q, rd_ptr_d;
  logic               do_push, do_pop;

  // Extra MSB distinguishes full from empty when the index bits match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[DepthLog2] != rd_ptr_q[DepthLog2]) &&
                   (wr_ptr_q[DepthLog2-1:0] == rd_ptr_q[DepthLog2-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  assign head_o      = mem_q[rd_ptr_q[DepthLog2-1:0]];
  assign head_next_o = mem_q[rd_ptr_q[DepthLog2-1:0] + IdxOne];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrOne;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrOne;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[DepthLog2-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/rx_stream_packer.sv
// Buffers decimated I/Q pairs and emits them as I-then-Q AXI4-Stream beats with framed TLAST.
module rx_stream_packer
  import rx_stream_packer_pkg::*;
#(
    parameter int unsigned SampleWidth   = 24,
    parameter int unsigned FifoDepthLog2 = 4,
    parameter int unsigned FrameSamples  = 256
) (
    input  logic                   clock_i,
    input  logic                   not_reset_i,
    input  logic                   enable_i,
    input  logic                   in_strobe_i,
    input  logic [SampleWidth-1:0] in_i_i,
    input  logic [SampleWidth-1:0] in_q_i,
    input  logic                   clear_overflow_i,
    output logic [OvfWidth-1:0]    overflow_count_o,
    rx_stream_packer_if.master     m
);

  localparam int unsigned PairWidth = 2 * SampleWidth;
  localparam int unsigned FrameCntWidth = (FrameSamples > 1) ? $clog2(FrameSamples) : 1;
  localparam logic [FrameCntWidth-1:0] FrameLast   = FrameCntWidth'(FrameSamples - 1);
  localparam logic [FrameCntWidth-1:0] FrameOne    = 1;
  localparam logic [OvfWidth-1:0]      OvfOne      = 1;
  localparam logic [FifoDepthLog2:0]   LevelTwo    = 2;

  function automatic logic [StreamWidth-1:0] sext(input logic [SampleWidth-1:0] s);
    return StreamWidth'($signed(s));
  endfunction

  logic [PairWidth-1:0]     fifo_head, fifo_head_next, next_pair;
  logic [FifoDepthLog2:0]   fifo_level;
  logic                     fifo_full, fifo_empty;
  logic                     push, drop, pop, more_after_pop;

  tx_state_e                state_q;
  logic                     tvalid_q, tlast_q;
  logic [StreamWidth-1:0]   tdata_q;
  logic [FrameCntWidth-1:0] frame_cnt_q;
  logic [OvfWidth-1:0]      ovf_q, ovf_d;

  // Full comes from registered pointers, so a same-cycle pop never rescues a strobe.
  assign push = in_strobe_i & enable_i & ~fifo_full;
  assign drop = in_strobe_i & enable_i & fifo_full;
  assign pop  = (state_q == StSendQ) & m.tready;

  // A write landing in the same cycle as the last pop keeps the stream going back-to-back.
  assign more_after_pop = (fifo_level >= LevelTwo) | push;
  assign next_pair      = (fifo_level >= LevelTwo) ? fifo_head_next : {in_i_i, in_q_i};

  rx_stream_packer_sync_fifo #(
      .Width    (PairWidth),
      .DepthLog2(FifoDepthLog2)
  ) u_fifo (
      .clk_i      (clock_i),
      .rst_ni     (not_reset_i),
      .push_i     (push),
      .wdata_i    ({in_i_i, in_q_i}),
      .pop_i      (pop),
      .head_o     (fifo_head),
      .head_next_o(fifo_head_next),
      .level_o    (fifo_level),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty)
  );

  always_comb begin
    ovf_d = ovf_q;
    if (clear_overflow_i) begin
      ovf_d = '0;
    end else if (drop && (ovf_q != '1)) begin
      ovf_d = ovf_q + OvfOne;
    end
  end

  always_ff @(posedge clock_i) begin
    if (!not_reset_i) begin
      state_q     <= StIdle;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tdata_q     <= '0;
      frame_cnt_q <= '0;
      ovf_q       <= '0;
    end else begin
      ovf_q <= ovf_d;
      unique case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            state_q  <= StSendI;
            tvalid_q <= 1'b1;
            tlast_q  <= 1'b0;
            tdata_q  <= sext(fifo_head[PairWidth-1:SampleWidth]);
          end
        end
        StSendI: begin
          if (m.tready) begin
            state_q <= StSendQ;
            tdata_q <= sext(fifo_head[SampleWidth-1:0]);
            tlast_q <= (frame_cnt_q == FrameLast);
          end
        end
        StSendQ: begin
          if (m.tready) begin
            tlast_q <= 1'b0;
            if (enable_i) begin
              frame_cnt_q <= (frame_cnt_q == FrameLast) ? '0 : frame_cnt_q + FrameOne;
            end
            if (more_after_pop) begin
              state_q <= StSendI;
              tdata_q <= sext(next_pair[PairWidth-1:SampleWidth]);
            end else begin
              state_q  <= StIdle;
              tvalid_q <= 1'b0;
              tdata_q  <= '0;
            end
          end
        end
        default: begin
          state_q  <= StIdle;
          tvalid_q <= 1'b0;
          tlast_q  <= 1'b0;
          tdata_q  <= '0;
        end
      endcase
    end
  end

  assign m.tvalid         = tvalid_q;
  assign m.tdata          = tdata_q;
  assign m.tlast          = tlast_q;
  assign overflow_count_o = ovf_q;

endmodule

// File: tb/tb_rx_stream_packer.sv
// Directed bench for rx_stream_packer built with a 4-pair frame so TLAST boundaries are reachable.
module tb_rx_stream_packer;

  localparam int unsigned Frame = 4;

  logic        clk = 1'b0;
  logic        not_reset = 1'b0;
  logic        enable = 1'b1;
  logic        in_strobe = 1'b0;
  logic [23:0] in_i = '0;
  logic [23:0] in_q = '0;
  logic        clear_ovf = 1'b0;
  logic [15:0] ovf_count;

  rx_stream_packer_if s_if ();

  rx_stream_packer #(
      .SampleWidth  (24),
      .FifoDepthLog2(4),
      .FrameSamples (Frame)
  ) dut (
      .clock_i         (clk),
      .not_reset_i     (not_reset),
      .enable_i        (enable),
      .in_strobe_i     (in_strobe),
      .in_i_i          (in_i),
      .in_q_i          (in_q),
      .clear_overflow_i(clear_ovf),
      .overflow_count_o(ovf_count),
      .m               (s_if.master)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h, expected %h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] sx(input logic [23:0] s);
    return {{8{s[23]}}, s};
  endfunction

  // Handshake recorder plus hold-while-stalled monitor.
  logic [32:0] beats[$];
  logic        stab_en = 1'b0;
  logic        prev_stall = 1'b0;
  logic [32:0] prev_beat = '0;

  always @(negedge clk) begin
    if (s_if.tvalid && s_if.tready) beats.push_back({s_if.tlast, s_if.tdata});
    if (stab_en && prev_stall)
      check("stall_hold", {s_if.tvalid, s_if.tlast, s_if.tdata}, {1'b1, prev_beat});
    prev_stall = s_if.tvalid & ~s_if.tready;
    prev_beat  = {s_if.tlast, s_if.tdata};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [23:0] i, input logic [23:0] q);
    in_strobe = 1'b1;
    in_i      = i;
    in_q      = q;
    tick();
    in_strobe = 1'b0;
  endtask

  task automatic do_reset();
    not_reset = 1'b0;
    tick();
    tick();
    not_reset = 1'b1;
  endtask

  task automatic drain(input string tag, input int max_cycles);
    int n = 0;
    s_if.tready = 1'b1;
    tick();
    while (s_if.tvalid && n < max_cycles) begin
      tick();
      n++;
    end
    tick();
    check(tag, {63'd0, s_if.tvalid}, 64'd0);
  endtask

  function automatic logic [23:0] pat_i(input int k);
    return 24'h800000 + 24'(k) * 24'h000111;
  endfunction

  function automatic logic [23:0] pat_q(input int k);
    return 24'h000100 + 24'(k) * 24'h010001;
  endfunction

  initial begin
    s_if.tready = 1'b0;
    do_reset();
    @(negedge clk);
    check("rst_tvalid", {63'd0, s_if.tvalid}, 64'd0);
    check("rst_tlast", {63'd0, s_if.tlast}, 64'd0);
    check("rst_tdata", {32'd0, s_if.tdata}, 64'd0);
    check("rst_ovf", {48'd0, ovf_count}, 64'd0);

    // 1: single sample, latency and sign extension
    tick();
    s_if.tready = 1'b1;
    beats.delete();
    strobe(24'h800001, 24'h7FFFFF);
    @(negedge clk);
    check("t1_lat_low", {63'd0, s_if.tvalid}, 64'd0);
    @(negedge clk);
    check("t1_i_beat", {31'd0, s_if.tvalid, s_if.tlast, s_if.tdata}, {31'd0, 2'b10, 32'hFF800001});
    @(negedge clk);
    check("t1_q_beat", {31'd0, s_if.tvalid, s_if.tlast, s_if.tdata}, {31'd0, 2'b10, 32'h007FFFFF});
    @(negedge clk);
    check("t1_idle", {63'd0, s_if.tvalid}, 64'd0);
    check("t1_nbeats", 64'(beats.size()), 64'd2);
    #1;

    // 2: stalled sink, 17 strobes, one dropped
    do_reset();
    s_if.tready = 1'b0;
    beats.delete();
    for (int k = 0; k < 17; k++) begin
      strobe(pat_i(k), pat_q(k));
      tick();
    end
    check("t2_ovf", {48'd0, ovf_count}, 64'd1);
    check("t2_head", {31'd0, s_if.tvalid, s_if.tlast, s_if.tdata}, {31'd0, 2'b10, sx(pat_i(0))});
    drain("t2_drain", 100);
    check("t2_nbeats", 64'(beats.size()), 64'd32);
    for (int b = 0; b < 32 && b < beats.size(); b++) begin
      check($sformatf("t2_beat%0d", b), {31'd0, beats[b]},
            {31'd0, ((b % 8) == 7), (b % 2 == 0) ? sx(pat_i(b / 2)) : sx(pat_q(b / 2))});
    end

    // 3: random backpressure, TLAST placement, hold while stalled
    do_reset();
    beats.delete();
    stab_en = 1'b1;
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          strobe(pat_q(k + 3), pat_i(k + 5));
          tick();
        end
      end
      begin
        for (int c = 0; c < 40; c++) begin
          s_if.tready = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    drain("t3_drain", 100);
    stab_en = 1'b0;
    check("t3_nbeats", 64'(beats.size()), 64'd16);
    for (int b = 0; b < 16 && b < beats.size(); b++) begin
      check($sformatf("t3_beat%0d", b), {31'd0, beats[b]},
            {31'd0, (b == 7 || b == 15), (b % 2 == 0) ? sx(pat_q(b / 2 + 3)) : sx(pat_i(b / 2 + 5))});
    end

    // 4: overflow saturation and clear priority
    do_reset();
    s_if.tready = 1'b0;
    in_strobe   = 1'b1;
    in_i        = 24'h123456;
    in_q        = 24'h654321;
    repeat (16 + 65534) tick();
    check("t4_ovf_fffe", {48'd0, ovf_count}, 64'hFFFE);
    tick();
    check("t4_ovf_ffff", {48'd0, ovf_count}, 64'hFFFF);
    repeat (2) tick();
    check("t4_ovf_sat", {48'd0, ovf_count}, 64'hFFFF);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    check("t4_ovf_clear", {48'd0, ovf_count}, 64'd0);
    tick();
    in_strobe = 1'b0;
    check("t4_ovf_after", {48'd0, ovf_count}, 64'd1);

    // 5: reset mid-frame discards the beat and restarts the frame count
    do_reset();
    s_if.tready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      strobe(pat_i(k), pat_q(k));
      repeat (4) tick();
    end
    s_if.tready = 1'b0;
    strobe(24'hABCDEF, 24'h012345);
    repeat (2) tick();
    check("t5_pre_valid", {63'd0, s_if.tvalid}, 64'd1);
    not_reset = 1'b0;
    tick();
    @(negedge clk);
    check("t5_rst_valid", {31'd0, s_if.tvalid, s_if.tlast, s_if.tdata}, 64'd0);
    check("t5_rst_ovf", {48'd0, ovf_count}, 64'd0);
    #1;
    not_reset = 1'b1;
    s_if.tready = 1'b1;
    beats.delete();
    for (int k = 0; k < 4; k++) begin
      strobe(pat_i(k + 9), pat_q(k + 9));
      tick();
    end
    drain("t5_drain", 50);
    check("t5_nbeats", 64'(beats.size()), 64'd8);
    for (int b = 0; b < 8 && b < beats.size(); b++) begin
      check($sformatf("t5_beat%0d", b), {31'd0, beats[b]},
            {31'd0, (b == 7), (b % 2 == 0) ? sx(pat_i(b / 2 + 9)) : sx(pat_q(b / 2 + 9))});
    end

    // 6: enable low ignores strobes but queued samples still drain
    do_reset();
    s_if.tready = 1'b0;
    beats.delete();
    for (int k = 0; k < 17; k++) strobe(pat_q(k), pat_i(k));
    check("t6_ovf_base", {48'd0, ovf_count}, 64'd1);
    enable = 1'b0;
    for (int k = 0; k < 5; k++) strobe(24'hFFFFFF, 24'hFFFFFF);
    check("t6_ovf_held", {48'd0, ovf_count}, 64'd1);
    check("t6_no_beats", 64'(beats.size()), 64'd0);
    drain("t6_drain", 100);
    check("t6_nbeats", 64'(beats.size()), 64'd32);
    if (beats.size() == 32) begin
      check("t6_first", {32'd0, beats[0][31:0]}, {32'd0, sx(pat_q(0))});
      check("t6_last", {32'd0, beats[31][31:0]}, {32'd0, sx(pat_i(15))});
    end
    enable = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
